// File: rtl/aes_stream_driver.sv
// Byte-stream front end for the AES core: packs 16 bytes, runs the core, unpacks result.
// Optional macro AES_TIMEOUT_EN aborts a RUN that exceeds TIMEOUT_CYCLES.
`timescale 1ns/1ps
module aes_stream_driver #(
    parameter int MSG_BYTES      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [0:7]   inByte,
    input  logic         inEncOrDec,
    input  logic [0:2]   inKeySize,
    output logic         outValid,
    input  logic         outReady,
    output logic [0:7]   outByte,
    output logic         busy,
    output logic         error,
    output logic         aesRun,
    output logic         aesEncOrDec,
    output logic [0:2]   aesKeySize,
    output logic [0:127] aesMessageIn,
    input  logic         aesDone,
    input  logic [0:127] aesMessageOut
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;
    localparam logic [3:0] LAST     = 4'(MSG_BYTES - 1);

    logic [1:0]   state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic [0:127] msg_q, msg_d;
    logic [0:127] res_q, res_d;
    logic         enc_q, enc_d;
    logic [0:2]   key_q, key_d;
    logic         first_q, first_d;
    logic         err_q, err_d;
    logic         timeout;
    logic         in_fire;
    logic         out_fire;
    logic [6:0]   bidx;

`ifdef AES_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q, timer_d;

    // Held at zero outside RUN, so it restarts on every RUN entry.
    always_comb begin
        timer_d = '0;
        if (state_q == S_RUN) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout = (state_q == S_RUN) &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // inReady is gated by reset so it reads 0 while reset is held.
    assign inReady  = reset &&
                      ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign outValid = (state_q == S_UNLOAD);
    assign busy     = (state_q != S_IDLE);
    assign aesRun   = (state_q == S_RUN);
    assign error    = err_q;
    assign in_fire  = inValid && inReady;
    assign out_fire = outValid && outReady;
    assign bidx     = {count_q, 3'b000};
    assign outByte  = outValid ? res_q[bidx +: 8] : 8'h00;

    assign aesEncOrDec  = enc_q;
    assign aesKeySize   = key_q;
    assign aesMessageIn = msg_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        msg_d   = msg_q;
        res_d   = res_q;
        enc_d   = enc_q;
        key_d   = key_q;
        first_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    enc_d       = inEncOrDec;
                    key_d       = inKeySize;
                    msg_d[0:7]  = inByte;
                    count_d     = 4'd1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    msg_d[bidx +: 8] = inByte;
                    count_d          = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = S_RUN;
                        first_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Core is just leaving reset on the first cycle; done is stale.
                if (aesDone && !first_q) begin
                    res_d   = aesMessageOut;
                    state_d = S_UNLOAD;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    count_d = 4'd0;
                    state_d = S_IDLE;
                end
            end
            S_UNLOAD: begin
                if (out_fire) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            msg_q   <= '0;
            res_q   <= '0;
            enc_q   <= 1'b0;
            key_q   <= 3'b000;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            msg_q   <= msg_d;
            res_q   <= res_d;
            enc_q   <= enc_d;
            key_q   <= key_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_aes_stream_driver.sv
// Bench for aes_stream_driver: mock AES core, byte scoreboard, directed messages.
// Build with AES_TIMEOUT_EN defined to also exercise the RUN timeout abort.
`timescale 1ns/1ps
module tb_aes_stream_driver;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         inValid;
    logic         inReady;
    logic [0:7]   inByte;
    logic         inEncOrDec;
    logic [0:2]   inKeySize;
    logic         outValid;
    logic         outReady;
    logic [0:7]   outByte;
    logic         busy;
    logic         error;
    logic         aesRun;
    logic         aesEncOrDec;
    logic [0:2]   aesKeySize;
    logic [0:127] aesMessageIn;
    logic         aesDone;
    logic [0:127] aesMessageOut;

    aes_stream_driver #(
        .MSG_BYTES(16),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .inValid(inValid),
        .inReady(inReady),
        .inByte(inByte),
        .inEncOrDec(inEncOrDec),
        .inKeySize(inKeySize),
        .outValid(outValid),
        .outReady(outReady),
        .outByte(outByte),
        .busy(busy),
        .error(error),
        .aesRun(aesRun),
        .aesEncOrDec(aesEncOrDec),
        .aesKeySize(aesKeySize),
        .aesMessageIn(aesMessageIn),
        .aesDone(aesDone),
        .aesMessageOut(aesMessageOut)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int popped = 0;
    int err_cnt = 0;
    int run_hi = 0;

    int done_at = 10;
    bit early_done = 1'b0;
    bit idle_done = 1'b0;
    bit toggle_en = 1'b0;
    int tog_i = 0;

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Mock core: done after done_at RUN cycles, result = ~messageIn.
    initial begin
        int run_idx;
        bit prev_run;
        run_idx = 0;
        prev_run = 1'b0;
        aesDone = 1'b0;
        aesMessageOut = '0;
        forever begin
            @(posedge clock);
            #1;
            if (aesRun) begin
                run_idx = prev_run ? run_idx + 1 : 0;
                prev_run = 1'b1;
                aesDone = (run_idx == done_at) ||
                          (early_done && run_idx == 0);
            end else begin
                prev_run = 1'b0;
                run_idx = 0;
                aesDone = idle_done;
            end
            aesMessageOut = aesDone ? ~aesMessageIn : '0;
        end
    end

    // Host sink: always ready, or the 1-0-0-1 pattern.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (toggle_en) begin
                outReady = (tog_i % 4 == 0) || (tog_i % 4 == 3);
                tog_i++;
            end else begin
                outReady = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops, stall-hold checks, error/aesRun counting.
    initial begin
        bit prev_stall;
        logic [7:0] prev_byte;
        prev_stall = 1'b0;
        prev_byte = 8'h00;
        forever begin
            @(negedge clock);
            if (aesRun) run_hi++;
            if (error) err_cnt++;
            if (prev_stall && outValid)
                check("hold", outByte, prev_byte);
            prev_stall = outValid && !outReady;
            prev_byte = outByte;
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h expected none",
                             outByte);
                end else begin
                    check("outbyte", outByte, exp_q.pop_front());
                end
                popped++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b,
                             input logic enc,
                             input logic [2:0] key);
        int n;
        inValid = 1'b1;
        inByte = b;
        inEncOrDec = enc;
        inKeySize = key;
        n = 0;
        @(negedge clock);
        while (!inReady && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (!inReady) begin
            total++;
            bad++;
            $display("FAIL send_ready: got 0 expected 1");
        end
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] base,
                            input logic [7:0] step,
                            input logic enc,
                            input logic [2:0] key0,
                            input logic [2:0] key1,
                            input int sw,
                            output logic [127:0] msg);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = base + step * 8'(i);
            msg[127 - 8*i -: 8] = b;
            exp_q.push_back(~b);
            send_byte(b, enc, (i >= sw) ? key1 : key0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] m;
        inValid = 1'b0;
        inByte = 8'h00;
        inEncOrDec = 1'b0;
        inKeySize = 3'b000;

        #15;
        check("reset_ctl",
              {inReady, outValid, busy, error, aesRun,
               aesEncOrDec, aesKeySize, outByte}, 0);
        check("reset_msg", aesMessageIn, 0);
        #12 reset = 1'b1;
        @(negedge clock);
        check("idle_ready", {inReady, busy}, 2'b10);
        @(posedge clock);
        #1;

        // Message 00 11 .. ff, result bytes ff ee .. 00.
        run_hi = 0;
        popped = 0;
        send_msg(8'h00, 8'h11, 1'b1, 3'b000, 3'b000, 16, m);
        check("msg_in", aesMessageIn,
              128'h00112233445566778899aabbccddeeff);
        @(negedge clock);
        check("run_entry", {busy, inReady, aesRun, aesEncOrDec},
              4'b1011);
        wait_idle("t1");
        check("run_len", run_hi, 11);
        check("t1_count", popped, 16);

        // Host stalls 1-0-0-1 during unload.
        @(posedge clock);
        #1;
        toggle_en = 1'b1;
        tog_i = 0;
        popped = 0;
        send_msg(8'h00, 8'h11, 1'b1, 3'b000, 3'b000, 16, m);
        wait_idle("t2");
        check("t2_count", popped, 16);
        check("t2_busy", busy, 0);
        toggle_en = 1'b0;

        // Done on first RUN cycle must be ignored; real capture at 5.
        @(posedge clock);
        #1;
        early_done = 1'b1;
        done_at = 5;
        run_hi = 0;
        send_msg(8'h5a, 8'h07, 1'b0, 3'b100, 3'b100, 16, m);
        check("t3_msg", aesMessageIn, m);
        wait_idle("t3");
        check("t3_run_len", run_hi, 6);
        early_done = 1'b0;
        done_at = 10;

        // Reset after 7 bytes, then a clean message.
        @(posedge clock);
        #1;
        for (int i = 0; i < 7; i++)
            send_byte(8'(8'h81 + i), 1'b1, 3'b011);
        reset = 1'b0;
        #1;
        check("midrst_ctl",
              {inReady, outValid, busy, error, aesRun,
               aesEncOrDec, aesKeySize, outByte}, 0);
        check("midrst_msg", aesMessageIn, 0);
        #5 reset = 1'b1;
        @(posedge clock);
        #1;
        popped = 0;
        send_msg(8'hf0, 8'h03, 1'b0, 3'b101, 3'b101, 16, m);
        check("t4_msg", aesMessageIn, m);
        check("t4_mode", {aesEncOrDec, aesKeySize}, 4'b0101);
        wait_idle("t4");
        check("t4_count", popped, 16);

        // Key change mid-load ignored; stray done pulses while idle/load.
        @(posedge clock);
        #1;
        idle_done = 1'b1;
        popped = 0;
        send_msg(8'h10, 8'h01, 1'b1, 3'b010, 3'b001, 3, m);
        @(negedge clock);
        check("t5_key_run0", aesKeySize, 3'b010);
        repeat (3) @(negedge clock);
        check("t5_key_run3", {aesRun, aesKeySize}, 4'b1010);
        wait_idle("t5");
        check("t5_count", popped, 16);
        repeat (4) @(negedge clock);
        check("t5_idle_done", {busy, outValid}, 2'b00);
        idle_done = 1'b0;

`ifdef AES_TIMEOUT_EN
        begin
            int errs;
            int first_idx;
            @(posedge clock);
            #1;
            done_at = 1_000_000;
            popped = 0;
            errs = 0;
            first_idx = -1;
            for (int i = 0; i < 16; i++)
                send_byte(8'(i), 1'b1, 3'b000);
            for (int idx = 0; idx < 60; idx++) begin
                @(negedge clock);
                if (error) begin
                    errs++;
                    if (first_idx < 0) first_idx = idx;
                    check("to_run_low", aesRun, 0);
                end
            end
            check("to_err_cnt", errs, 1);
            check("to_err_at", first_idx, 32);
            check("to_idle", {busy, inReady}, 2'b01);
            check("to_no_out", popped, 0);
            done_at = 10;
        end
`else
        check("no_error", err_cnt, 0);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
